// File: rtl/irq_ctrl.sv
// irq_ctrl: synchronised, maskable, fixed-priority interrupt controller
// driving the core's irq_req / irq_id / irq_ack handshake.
module irq_ctrl #(
   parameter int                 NUM_IRQ     = 16,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_IRQ-1:0] RST_ENABLE  = '0,
   parameter logic [NUM_IRQ-1:0] RST_MODE    = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_src,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic [31:0]        cfg_rdata,
   output logic               irq_req,
   output logic [4:0]         irq_id,
   input  logic               irq_ack
);

   typedef enum logic [1:0] {IDLE, REQ, ACKED} state_t;

   state_t             state;
   state_t             state_n;
   logic               req_n;
   logic [4:0]         id_n;
   logic               ack_hit;

   logic [NUM_IRQ-1:0] s;
   logic [NUM_IRQ-1:0] prev;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] pend_n;
   logic [NUM_IRQ-1:0] enable;
   logic [NUM_IRQ-1:0] mode;
   logic               gie;

   logic [NUM_IRQ-1:0] wdat;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] mode_chg;
   logic [NUM_IRQ-1:0] w1c;
   logic [NUM_IRQ-1:0] ack_mask;
   logic [NUM_IRQ-1:0] eligible;
   logic [4:0]         winner;
   logic               wr_en;
   logic               wr_mode;
   logic               wr_pend;
   logic               wr_ctrl;
   logic               unused_wdata;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = irq_src;
      end else begin : g_sync
         logic [NUM_IRQ-1:0] stage [SYNC_STAGES];
         always_ff @(posedge clk) begin
            if (reset) begin
               stage <= '{default: '0};
            end else begin
               stage[0] <= irq_src;
               for (int k = 1; k < SYNC_STAGES; k++)
                  stage[k] <= stage[k-1];
            end
         end
         assign s = stage[SYNC_STAGES-1];
      end
   endgenerate

   assign wdat         = cfg_wdata[NUM_IRQ-1:0];
   assign unused_wdata = ^cfg_wdata;
   assign wr_en        = cfg_we && (cfg_addr == 2'd0);
   assign wr_mode      = cfg_we && (cfg_addr == 2'd1);
   assign wr_pend      = cfg_we && (cfg_addr == 2'd2);
   assign wr_ctrl      = cfg_we && (cfg_addr == 2'd3);

   assign rise     = s & ~prev;
   assign mode_chg = wr_mode ? (wdat ^ mode) : '0;
   assign w1c      = wr_pend ? (wdat & mode) : '0;
   assign ack_mask = ack_hit ? ((NUM_IRQ'(1) << irq_id) & mode) : '0;
   assign eligible = pend & enable & {NUM_IRQ{gie}};

   // Edge bits: a new rise beats any clear in the same cycle.
   assign pend_n = ((mode & (rise | (pend & ~(w1c | ack_mask))))
                   | (~mode & s)) & ~mode_chg;

   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (eligible[i]) winner = 5'(i);
   end

   always_comb begin
      state_n = state;
      req_n   = irq_req;
      id_n    = irq_id;
      ack_hit = 1'b0;
      unique case (state)
         IDLE: begin
            if (|eligible) begin
               state_n = REQ;
               req_n   = 1'b1;
               id_n    = winner;
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_n = ACKED;
               req_n   = 1'b0;
               ack_hit = 1'b1;
            end
         end
         ACKED:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         irq_req <= 1'b0;
         irq_id  <= '0;
      end else begin
         state   <= state_n;
         irq_req <= req_n;
         irq_id  <= id_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         enable <= RST_ENABLE;
         mode   <= RST_MODE;
         gie    <= 1'b0;
         pend   <= '0;
         prev   <= '0;
      end else begin
         prev <= s;
         pend <= pend_n;
         if (wr_en)   enable <= wdat;
         if (wr_mode) mode   <= wdat;
         if (wr_ctrl) gie    <= cfg_wdata[0];
      end
   end

   always_comb begin
      cfg_rdata = '0;
      unique case (cfg_addr)
         2'd0:    cfg_rdata = 32'(enable);
         2'd1:    cfg_rdata = 32'(mode);
         2'd2:    cfg_rdata = 32'(pend);
         default: cfg_rdata = {26'b0, irq_req, irq_id};
      endcase
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Parametrised interrupt controller that drives the core's irq_req/irq_id/irq_ack handshake, which is currently tied off.
- Collects up to 32 external interrupt sources.
- Per source: optional synchronisation, level or edge mode, enable mask and pending tracking.
- Fixed-priority arbitration: lowest index wins.
- Presents one stable request to the ID stage and holds it until acknowledged.

Parameters:
NUM_IRQ, 16, number of sources (1..32).
SYNC_STAGES, 2, synchroniser flops per source (0..3); 0 means sources are already in the clk domain.
RST_ENABLE, 0, reset value of ENABLE register (NUM_IRQ bits).
RST_MODE, 0, reset value of MODE register (1 = edge, 0 = level).

Ports:
clk  input  1  core clock.
reset  input  1  synchronous reset, active-high.
irq_src  input  NUM_IRQ  raw interrupt sources, active-high.
cfg_we  input  1  config write strobe, one cycle.
cfg_addr  input  2  register select: 0 ENABLE, 1 MODE, 2 PENDING, 3 CTRL.
cfg_wdata  input  32  write data; bits >= NUM_IRQ ignored.
cfg_rdata  output  32  combinational read of cfg_addr; unused bits 0.
irq_req  output  1  interrupt request to core.
irq_id  output  5  index of requested source; stable while irq_req=1.
irq_ack  input  1  core accepts request; meaningful only while irq_req=1.

Behaviour:
- Domain and reset: single clk domain. Reset is synchronous, active-high (already decided). Reset values:
  - irq_req=0, irq_id=0.
  - ENABLE=RST_ENABLE, MODE=RST_MODE, pending=0, CTRL.gie=0.
  - sync and edge-history flops cleared.
  - FSM=IDLE.
- Reset mid-request: irq_req drops the cycle after reset is sampled. A pending ack is lost, with no side effects.
- Synchroniser: s[i] = irq_src[i] delayed SYNC_STAGES flops; prev[i] = s[i] delayed one cycle.
- Pending:
  - Edge mode: pend[i] is set when s[i]&~prev[i]. It is cleared by ack of i or by a CFG W1C write. A set in the same cycle as a clear: set wins.
  - Level mode: pend[i] = registered s[i]. W1C has no effect.
- Pending is tracked regardless of ENABLE. The eligible set is pend & ENABLE & {NUM_IRQ{gie}}.
- Arbitration: lowest-index eligible source, evaluated only in IDLE.
- FSM:
  - IDLE: if eligible is non-zero, go to REQ. irq_req<=1 and irq_id<=winner are both registered.
  - REQ: hold irq_req=1 and irq_id unchanged, even if the source drops, is disabled or gie is cleared; the request is sticky until ack. On irq_ack: clear pend[irq_id] if that source is edge mode, irq_req<=0, go to ACKED.
  - ACKED: single gap cycle so the updated pending is seen, then IDLE.
- Timing:
  - irq_req rises SYNC_STAGES+2 cycles after the first clk edge sampling irq_src high (4 cycles with defaults). A CFG enable write adds 1 cycle.
  - After ack, irq_req stays low for at least 2 cycles.
  - irq_ack while irq_req=0 is ignored.
- CFG writes take effect at the clock edge:
  - ENABLE and MODE are plain registers. Changing MODE clears pend for the changed bits.
  - PENDING is W1C for edge sources.
  - CTRL: bit0 gie. Read of CTRL = {26'b0, irq_req, irq_id}; the other CTRL bits are read-only.
  - PENDING read returns pend.
- Edges shorter than 1 clk on async inputs are not guaranteed to be captured. Back-to-back edges before ack are counted once.

Test Plan:
- Basic edge: MODE=0x1, ENABLE=0x1, gie=1; pulse irq_src[0] 1 cycle -> irq_req=1, irq_id=0 exactly 4 cycles after sample. Ack -> PENDING reads 0; irq_req stays 0.
- Priority: level sources 3 and 7 asserted together, all enabled -> id=3. Ack and keep src3 high -> re-request id=3 after 2-cycle gap. Drop src3 -> next request id=7.
- Masking: pend[5] set with ENABLE[5]=0 -> no irq_req, PENDING bit5=1. Write ENABLE=0x20 -> irq_req after 1 cycle, id=5.
- Sticky request: during REQ for id=2, deassert level src2 and write gie=0 -> irq_req and irq_id=2 held until ack. Then no new request.
- Collision: edge on src1 in the same cycle as ack of id=1, and separately W1C of bit1 coinciding with a new edge -> PENDING bit1 remains 1 and a new request id=1 follows.
- Reset mid-operation: assert reset while irq_req=1 -> next cycle irq_req=0, irq_id=0, PENDING=0, ENABLE=RST_ENABLE. Repeat with NUM_IRQ=32, SYNC_STAGES=0: src31 edge gives id=31 with 2-cycle latency.
